// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: sends the PC to memory as a word read, waits for MFC,
// then strobes the fetched word into the IR. Misalignment and timeouts become SPARC traps.
module instr_fetch_unit #(
  parameter int unsigned TIMEOUT    = 15,
  parameter logic [5:0]  RD_WORD_OP = 6'b001000
) (
  input  logic        Clk,
  input  logic        RESET,
  input  logic        fetch_req,
  input  logic        flush,
  input  logic [31:0] pc,
  input  logic        MFC,
  input  logic [31:0] mem_data,
  output logic [31:0] mem_addr,
  output logic [5:0]  RAM_OpCode,
  output logic        RAM_enable,
  output logic [31:0] IR_In,
  output logic        IR_Enable,
  output logic        busy,
  output logic        fetch_done,
  output logic        fetch_trap,
  output logic [7:0]  fetch_tt
);

  typedef enum logic [1:0] {IDLE, WAIT, LOAD, TRAP} state_t;

  localparam logic [7:0] TT_NOT_ALIGNED = 8'h07;
  localparam logic [7:0] TT_ACCESS_EXC  = 8'h01;
  localparam logic [7:0] CNT_LAST       = 8'(TIMEOUT - 1);

  state_t      state, next_state;
  logic [7:0]  wait_cnt;
  logic [7:0]  trap_tt;
  logic [31:0] addr_q;
  logic [31:0] ir_data;
  logic        accept;
  logic        misaligned;
  logic        timed_out;

  assign accept     = fetch_req && !flush;
  assign misaligned = (pc[1:0] != 2'b00);
  assign timed_out  = (wait_cnt == CNT_LAST);

  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= next_state;
  end

  // Within WAIT, flush outranks MFC, which outranks the timeout.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (accept) next_state = misaligned ? TRAP : WAIT;
      WAIT: begin
        if (flush)          next_state = IDLE;
        else if (MFC)       next_state = LOAD;
        else if (timed_out) next_state = TRAP;
      end
      LOAD: next_state = IDLE;
      TRAP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      wait_cnt <= '0;
      trap_tt  <= '0;
      addr_q   <= '0;
      ir_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (misaligned) begin
              trap_tt <= TT_NOT_ALIGNED;
            end else begin
              addr_q   <= pc;
              wait_cnt <= '0;
            end
          end
        end
        WAIT: begin
          if (!flush) begin
            if (MFC)            ir_data  <= mem_data;
            else if (timed_out) trap_tt  <= TT_ACCESS_EXC;
            else                wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // A flush during LOAD only squashes the IR strobe; the captured word stays visible.
  always_comb begin
    RAM_enable = (state == WAIT);
    RAM_OpCode = RAM_enable ? RD_WORD_OP : 6'd0;
    IR_Enable  = (state == LOAD) && !flush;
    fetch_done = IR_Enable;
    fetch_trap = (state == TRAP);
    fetch_tt   = fetch_trap ? trap_tt : 8'h00;
    busy       = (state != IDLE);
    mem_addr   = addr_q;
    IR_In      = ir_data;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, hand sequences for
// reset/busy/throughput, and random fetches checked against a transaction-level model.
module tb_instr_fetch_unit;

  localparam int         TIMEOUT_TB = 15;
  localparam logic [5:0] RD_OP      = 6'b001000;

  logic        Clk;
  logic        RESET;
  logic        fetch_req;
  logic        flush;
  logic [31:0] pc;
  logic        MFC;
  logic [31:0] mem_data;
  logic [31:0] mem_addr;
  logic [5:0]  RAM_OpCode;
  logic        RAM_enable;
  logic [31:0] IR_In;
  logic        IR_Enable;
  logic        busy;
  logic        fetch_done;
  logic        fetch_trap;
  logic [7:0]  fetch_tt;

  int assertions = 0;
  int failures   = 0;

  logic [31:0] ir_model;
  logic [31:0] addr_model;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          mfc_at;
    int          flush_at;
  } txn_t;

  typedef struct {
    int          ram_cycles;
    int          loads;
    int          load_edge;
    int          traps;
    int          trap_edge;
    logic [7:0]  tt;
    logic [31:0] ir;
    logic [31:0] addr;
  } res_t;

  typedef struct {
    txn_t t;
    res_t e;
  } vec_t;

  instr_fetch_unit #(.TIMEOUT(TIMEOUT_TB), .RD_WORD_OP(RD_OP)) dut (
    .Clk        (Clk),
    .RESET      (RESET),
    .fetch_req  (fetch_req),
    .flush      (flush),
    .pc         (pc),
    .MFC        (MFC),
    .mem_data   (mem_data),
    .mem_addr   (mem_addr),
    .RAM_OpCode (RAM_OpCode),
    .RAM_enable (RAM_enable),
    .IR_In      (IR_In),
    .IR_Enable  (IR_Enable),
    .busy       (busy),
    .fetch_done (fetch_done),
    .fetch_trap (fetch_trap),
    .fetch_tt   (fetch_tt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Outcome of one fetch walked edge by edge from the request: flush beats MFC beats timeout.
  function automatic res_t predict(input txn_t t, input logic [31:0] ir_prev, input logic [31:0] addr_prev);
    res_t e;
    e = '{default: 0};
    e.ir   = ir_prev;
    e.addr = addr_prev;
    if (t.pc[1:0] != 2'b00) begin
      e.traps = 1; e.trap_edge = 0; e.tt = 8'h07;
      return e;
    end
    e.addr = t.pc;
    for (int k = 1; k <= TIMEOUT_TB; k++) begin
      e.ram_cycles = k;
      if (t.flush_at == k) return e;
      if (t.mfc_at == k) begin
        e.ir        = t.data;
        e.load_edge = k;
        e.loads     = (t.flush_at == k + 1) ? 0 : 1;
        return e;
      end
    end
    e.traps = 1; e.trap_edge = TIMEOUT_TB; e.tt = 8'h01;
    return e;
  endfunction

  task automatic applyStimulus(input txn_t t, output res_t o, output int strobe_errs, output bit hung);
    o = '{default: 0};
    strobe_errs = 0;
    hung = 1'b1;
    @(negedge Clk);
    pc = t.pc; mem_data = t.data; fetch_req = 1'b1; MFC = 1'b0; flush = 1'b0;
    @(posedge Clk);
    for (int j = 1; j <= 40; j++) begin
      @(negedge Clk);
      fetch_req = 1'b0;
      MFC   = (j == t.mfc_at);
      flush = (j == t.flush_at);
      #1;
      if (RAM_enable) o.ram_cycles++;
      if (RAM_OpCode !== (RAM_enable ? RD_OP : 6'd0)) strobe_errs++;
      if (fetch_done !== IR_Enable) strobe_errs++;
      if (IR_Enable) begin o.loads++; o.load_edge = j - 1; end
      if (fetch_trap) begin o.traps++; o.trap_edge = j - 1; o.tt = fetch_tt; end
      else if (fetch_tt !== 8'h00) strobe_errs++;
      if (!busy) begin hung = 1'b0; break; end
    end
    MFC = 1'b0; flush = 1'b0;
    o.ir   = IR_In;
    o.addr = mem_addr;
  endtask

  task automatic checkTxn(input string tag, input res_t o, input res_t e, input int strobe_errs, input bit hung);
    checkOutput({tag, ".bound"}, 32'(hung), 32'd0);
    checkOutput({tag, ".ram_cycles"}, o.ram_cycles, e.ram_cycles);
    checkOutput({tag, ".ir_loads"}, o.loads, e.loads);
    if (e.loads != 0) checkOutput({tag, ".load_edge"}, o.load_edge, e.load_edge);
    checkOutput({tag, ".traps"}, o.traps, e.traps);
    if (e.traps != 0) begin
      checkOutput({tag, ".trap_edge"}, o.trap_edge, e.trap_edge);
      checkOutput({tag, ".fetch_tt"}, 32'(o.tt), 32'(e.tt));
    end
    checkOutput({tag, ".IR_In"}, o.ir, e.ir);
    checkOutput({tag, ".mem_addr"}, o.addr, e.addr);
    checkOutput({tag, ".strobes"}, strobe_errs, 0);
    ir_model   = e.ir;
    addr_model = e.addr;
  endtask

  initial begin
    vec_t  vecs[9];
    res_t  o, e;
    txn_t  t;
    int    serr;
    bit    hung;
    int    pulses, ram_cnt;
    logic [31:0] r;

    // Hand-derived vectors, applied in order so IR_In/mem_addr history carries over.
    vecs[0] = '{'{32'h0000_0040, 32'h8200_6000, 1, 0},  '{1,  1, 1,  0, 0,  8'h00, 32'h8200_6000, 32'h0000_0040}};
    vecs[1] = '{'{32'h0000_0100, 32'h1111_1111, 5, 0},  '{5,  1, 5,  0, 0,  8'h00, 32'h1111_1111, 32'h0000_0100}};
    vecs[2] = '{'{32'h0000_0042, 32'hDEAD_BEEF, 1, 0},  '{0,  0, 0,  1, 0,  8'h07, 32'h1111_1111, 32'h0000_0100}};
    vecs[3] = '{'{32'h0000_0200, 32'hCAFE_0000, 0, 0},  '{15, 0, 0,  1, 15, 8'h01, 32'h1111_1111, 32'h0000_0200}};
    vecs[4] = '{'{32'h0000_0300, 32'h2222_2222, 3, 3},  '{3,  0, 0,  0, 0,  8'h00, 32'h1111_1111, 32'h0000_0300}};
    vecs[5] = '{'{32'h0000_0304, 32'h3333_3333, 15, 0}, '{15, 1, 15, 0, 0,  8'h00, 32'h3333_3333, 32'h0000_0304}};
    vecs[6] = '{'{32'h0000_0308, 32'h4444_4444, 2, 3},  '{2,  0, 0,  0, 0,  8'h00, 32'h4444_4444, 32'h0000_0308}};
    vecs[7] = '{'{32'h0000_0001, 32'h5555_5555, 0, 1},  '{0,  0, 0,  1, 0,  8'h07, 32'h4444_4444, 32'h0000_0308}};
    vecs[8] = '{'{32'h0000_030C, 32'h6666_6666, 0, 16}, '{15, 0, 0,  1, 15, 8'h01, 32'h4444_4444, 32'h0000_030C}};

    RESET = 1'b0; fetch_req = 1'b0; flush = 1'b0; pc = '0; MFC = 1'b0; mem_data = '0;
    #3;
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.RAM_enable", 32'(RAM_enable), 32'd0);
    checkOutput("reset.RAM_OpCode", 32'(RAM_OpCode), 32'd0);
    checkOutput("reset.IR_Enable", 32'(IR_Enable), 32'd0);
    checkOutput("reset.fetch_trap", 32'(fetch_trap), 32'd0);
    checkOutput("reset.fetch_tt", 32'(fetch_tt), 32'd0);
    checkOutput("reset.IR_In", IR_In, 32'd0);
    checkOutput("reset.mem_addr", mem_addr, 32'd0);
    repeat (2) @(negedge Clk);
    RESET = 1'b1;
    ir_model = '0; addr_model = '0;

    $display("[TB] directed vectors");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].t, o, serr, hung);
      checkTxn($sformatf("vec%0d", i), o, vecs[i].e, serr, hung);
    end

    // A request held high while busy must neither re-latch mem_addr nor queue.
    $display("[TB] busy ignores fetch_req");
    @(negedge Clk);
    pc = 32'h0000_0400; fetch_req = 1'b1; MFC = 1'b0; mem_data = 32'h55AA_55AA;
    @(negedge Clk);
    pc = 32'h0000_0500;
    repeat (3) @(negedge Clk);
    #1;
    checkOutput("busyreq.mem_addr", mem_addr, 32'h0000_0400);
    checkOutput("busyreq.busy", 32'(busy), 32'd1);
    fetch_req = 1'b0; MFC = 1'b1;
    @(negedge Clk);
    MFC = 1'b0;
    #1;
    checkOutput("busyreq.IR_Enable", 32'(IR_Enable), 32'd1);
    checkOutput("busyreq.IR_In", IR_In, 32'h55AA_55AA);
    @(negedge Clk);
    #1;
    checkOutput("busyreq.idle", 32'(busy), 32'd0);
    checkOutput("busyreq.mem_addr_held", mem_addr, 32'h0000_0400);
    ir_model = 32'h55AA_55AA; addr_model = 32'h0000_0400;

    // Zero-wait memory with a permanent request: one IR load every three cycles.
    $display("[TB] back-to-back throughput");
    @(negedge Clk);
    pc = 32'h0000_0700; mem_data = 32'h7777_0000; fetch_req = 1'b1; MFC = 1'b1;
    pulses = 0; ram_cnt = 0;
    repeat (12) begin
      @(negedge Clk);
      #1;
      if (IR_Enable) pulses++;
      if (RAM_enable) ram_cnt++;
    end
    fetch_req = 1'b0; MFC = 1'b0;
    checkOutput("b2b.ir_loads", pulses, 4);
    checkOutput("b2b.ram_cycles", ram_cnt, 4);
    @(negedge Clk);
    #1;
    checkOutput("b2b.idle", 32'(busy), 32'd0);
    ir_model = 32'h7777_0000; addr_model = 32'h0000_0700;

    // Reset dropped between edges in WAIT must clear outputs without a clock edge.
    $display("[TB] async reset in WAIT");
    @(negedge Clk);
    pc = 32'h0000_0600; fetch_req = 1'b1; MFC = 1'b0;
    @(negedge Clk);
    fetch_req = 1'b0;
    @(posedge Clk);
    #2 RESET = 1'b0;
    #1;
    checkOutput("areset.RAM_enable", 32'(RAM_enable), 32'd0);
    checkOutput("areset.busy", 32'(busy), 32'd0);
    checkOutput("areset.mem_addr", mem_addr, 32'd0);
    checkOutput("areset.IR_In", IR_In, 32'd0);
    checkOutput("areset.IR_Enable", 32'(IR_Enable), 32'd0);
    @(negedge Clk);
    RESET = 1'b1;
    ir_model = '0; addr_model = '0;
    t = '{32'h0000_0604, 32'h9999_0001, 2, 0};
    e = predict(t, ir_model, addr_model);
    applyStimulus(t, o, serr, hung);
    checkTxn("areset.refetch", o, e, serr, hung);

    $display("[TB] random fetches");
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      if ($urandom_range(0, 3) == 0) r[1:0] = 2'($urandom_range(1, 3));
      else                           r[1:0] = 2'b00;
      t.pc       = r;
      t.data     = $urandom;
      t.mfc_at   = $urandom_range(0, 17);
      t.flush_at = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 18) : 0;
      e = predict(t, ir_model, addr_model);
      applyStimulus(t, o, serr, hung);
      checkTxn($sformatf("rnd%0d", i), o, e, serr, hung);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
